can_crc_seq: RTL

Bit-serial CAN CRC-15 sequencer between the bit-timing/destuff logic and the frame FSM. Accumulates CRC-15 (poly x^15+x^14+x^10+x^8+x^7+x^4+x^3+1) over the frame bits, SOF through the data field.
- TX mode: serialises the 15-bit CRC MSB-first under a ready handshake.
- RX mode: collects the 15 received CRC bits and flags a mismatch.
Also checks the field length against a maximum.

---
 rtl/can_crc_seq.sv | 89 ++++++++
 1 files changed

// File: rtl/can_crc_seq.sv
// can_crc_seq: bit-serial CAN CRC-15 accumulate, TX serialise and RX check sequencer
module can_crc_seq #(
  parameter int CRC_W = 15,
  parameter logic [CRC_W-1:0] POLY = 15'h4599,
  parameter int MAX_BITS = 103
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             last_bit,
  input  logic             crc_ready,
  output logic             crc_bit_out,
  output logic             crc_bit_valid,
  output logic [CRC_W-1:0] crc_value,
  output logic             busy,
  output logic             done,
  output logic             crc_err,
  output logic             len_err
);
  localparam int CW = $clog2(CRC_W + 1);
  typedef enum logic [2:0] {IDLE, ACCUM, TX_SHIFT, RX_COLLECT, FINISH} state_t;
  state_t           state;
  logic [CRC_W-1:0] crc;
  logic [CRC_W-2:0] rx_shift;
  logic [6:0]       bit_cnt;
  logic [CW-1:0]    crc_cnt;
  logic             mode_q;
  logic [CRC_W-1:0] crc_nxt;
  assign crc_nxt = {crc[CRC_W-2:0], 1'b0} ^ ((bit_in ^ crc[CRC_W-1]) ? POLY : '0);
  assign crc_value = crc;
  assign busy = state != IDLE;
  assign done = state == FINISH;
  assign crc_bit_valid = state == TX_SHIFT;
  assign crc_bit_out = crc_bit_valid & crc[CW'(CRC_W-1) - crc_cnt];
  // frame sequencing: start aborts anything in flight, otherwise step the current phase
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      crc <= '0;
      rx_shift <= '0;
      bit_cnt <= '0;
      crc_cnt <= '0;
      mode_q <= 1'b0;
      crc_err <= 1'b0;
      len_err <= 1'b0;
    end else if (start) begin
      state <= ACCUM;
      crc <= '0;
      rx_shift <= '0;
      bit_cnt <= '0;
      crc_cnt <= '0;
      mode_q <= mode;
      crc_err <= 1'b0;
      len_err <= 1'b0;
    end else
      case (state)
        ACCUM:
          if (bit_valid) begin
            crc <= crc_nxt;
            bit_cnt <= bit_cnt + 7'd1;
            if (last_bit) begin
              state <= mode_q ? RX_COLLECT : TX_SHIFT;
              crc_cnt <= '0;
            end else if (bit_cnt == 7'(MAX_BITS - 1)) begin
              len_err <= 1'b1;
              state <= FINISH;
            end
          end
        TX_SHIFT:
          if (crc_ready) begin
            crc_cnt <= crc_cnt + CW'(1);
            if (crc_cnt == CW'(CRC_W - 1)) state <= FINISH;
          end
        RX_COLLECT:
          if (bit_valid) begin
            rx_shift <= {rx_shift[CRC_W-3:0], bit_in};
            crc_cnt <= crc_cnt + CW'(1);
            if (crc_cnt == CW'(CRC_W - 1)) begin
              crc_err <= {rx_shift, bit_in} != crc;
              state <= FINISH;
            end
          end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule
